// File: rtl/instr_encoder.sv
// RV32I instruction encoder with li pseudo-op expansion; one-entry output register, word valid 1 cycle after accept.
// Backpressure: in_ready = IDLE & (out empty | out_ready); words hold stable while out_ready is low.
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  opc,
    input  logic        li,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err
);
    localparam logic [4:0] OPC_R      = 5'b01100;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;

    typedef enum logic {IDLE, LI_LO} state_t;

    state_t      r_state;
    logic        r_out_valid;
    logic [31:0] r_instr;
    logic        r_err;
    logic [4:0]  r_li_rd;
    logic [11:0] r_li_lo;

    logic        w_can_load;
    logic        w_fits12;
    logic        w_fits13;
    logic        w_fits21;
    logic [19:0] w_li_hi;
    logic [31:0] w_instr;
    logic        w_err;
    logic        w_li_two;

    assign w_can_load = !r_out_valid || out_ready;
    assign in_ready   = (r_state == IDLE) && w_can_load;
    assign out_valid  = r_out_valid;
    assign instr      = r_instr;
    assign err        = r_err;

    // Signed range checks: all bits above the field's sign bit must equal it.
    assign w_fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign w_fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);
    assign w_fits21 = (imm[31:20] == '0) || (imm[31:20] == '1);
    // (imm + 0x800)[31:12]: the carry out of the low 12 bits is exactly imm[11].
    assign w_li_hi  = imm[31:12] + {19'd0, imm[11]};

    always_comb begin
        w_instr  = 32'h0000_0013;
        w_err    = 1'b0;
        w_li_two = 1'b0;
        if (li) begin
            if (w_fits12) begin
                w_instr = {imm[11:0], 5'd0, 3'b000, rd, 7'b0010011};
            end else begin
                w_instr  = {w_li_hi, rd, 7'b0110111};
                w_li_two = (imm[11:0] != 12'd0);
            end
        end else begin
            case (opc)
                OPC_R: w_instr = {funct7, rs2, rs1, funct3, rd, opc, 2'b11};
                OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
                    w_instr = {imm[11:0], rs1, funct3, rd, opc, 2'b11};
                    w_err   = !w_fits12;
                end
                OPC_STORE: begin
                    w_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opc, 2'b11};
                    w_err   = !w_fits12;
                end
                OPC_BRANCH: begin
                    w_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opc, 2'b11};
                    w_err   = !w_fits13 || imm[0];
                end
                OPC_LUI, OPC_AUIPC: begin
                    w_instr = {imm[31:12], rd, opc, 2'b11};
                    w_err   = (imm[11:0] != 12'd0);
                end
                OPC_JAL: begin
                    w_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc, 2'b11};
                    w_err   = !w_fits21 || imm[0];
                end
                default: w_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_instr     <= 32'd0;
            r_err       <= 1'b0;
            r_li_rd     <= 5'd0;
            r_li_lo     <= 12'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && w_can_load) begin
                        r_out_valid <= 1'b1;
                        r_instr     <= w_instr;
                        r_err       <= w_err;
                        if (w_li_two) begin
                            r_state <= LI_LO;
                            r_li_rd <= rd;
                            r_li_lo <= imm[11:0];
                        end
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                LI_LO: begin
                    if (w_can_load) begin
                        r_out_valid <= 1'b1;
                        r_instr     <= {r_li_lo, r_li_rd, 3'b000, r_li_rd, 7'b0010011};
                        r_err       <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words queued at drive time, compared against words taken at the output.
module tb_instr_encoder;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opc;
    logic        li;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];

    instr_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opc      (opc),
        .li       (li),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .funct3   (funct3),
        .funct7   (funct7),
        .imm      (imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .instr    (instr),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs only change just after posedge, so a negedge sample shows the coming handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) obs_q.push_back({err, instr});
    end

    task automatic send(input logic l, input logic [4:0] o, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im, input int nexp,
                        input logic [32:0] e0, input logic [32:0] e1);
        bit acc;
        li = l; opc = o; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
        in_valid = 1'b1;
        if (nexp > 0) exp_q.push_back(e0);
        if (nexp > 1) exp_q.push_back(e1);
        acc = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1 within 50 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (obs_q.size() >= exp_q.size() && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d words, required %0d", obs_q.size(), exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; li = 1'b0; opc = 5'b00100;
        rd = 5'd1; rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0; funct7 = 7'd0; imm = 32'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        tests++; if (instr !== 32'd0) begin fails++; $display("FAIL reset_instr: got %h required 00000000", instr); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b required 0", err); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_basic();
        logic [32:0] e, o;
        send(1'b0, 5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, {1'b0, 32'h0050_0093}, '0);
        @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_latency: out_valid got %b required 1", out_valid); end
        tests++; if ({err, instr} !== {1'b0, 32'h0050_0093}) begin fails++; $display("FAIL basic_word: got instr=%h err=%b required 00500093 err=0", instr, err); end
        @(posedge clk); #1;
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL basic_missing: got none required %h err=%b", e[31:0], e[32]); end
            else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL basic_sb: got %h err=%b required %h err=%b", o[31:0], o[32], e[31:0], e[32]); end end
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL basic_extra: got %0d extra words required 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_formats();
        logic [32:0] e, o;
        int idx;
        out_ready = 1'b1;
        send(0, 5'b11000, 5'd0,  5'd1, 5'd2, 3'd0, 7'd0,   -32'sd4,       1, {1'b0, 32'hFE20_8EE3}, '0);
        send(0, 5'b11011, 5'd1,  5'd0, 5'd0, 3'd0, 7'd0,   32'd8,         1, {1'b0, 32'h0080_00EF}, '0);
        send(0, 5'b01100, 5'd3,  5'd4, 5'd5, 3'd0, 7'h20,  32'd0,         1, {1'b0, 32'h4052_01B3}, '0);
        send(0, 5'b01000, 5'd31, 5'd2, 5'd1, 3'd2, 7'd0,   -32'sd8,       1, {1'b0, 32'hFE11_2C23}, '0);
        send(0, 5'b01101, 5'd7,  5'd0, 5'd0, 3'd0, 7'd0,   32'hABCD_E000, 1, {1'b0, 32'hABCD_E3B7}, '0);
        send(0, 5'b00101, 5'd1,  5'd0, 5'd0, 3'd0, 7'd0,   32'h0000_1001, 1, {1'b1, 32'h0000_1097}, '0);
        send(0, 5'b11001, 5'd1,  5'd6, 5'd0, 3'd0, 7'd0,   -32'sd1,       1, {1'b0, 32'hFFF3_00E7}, '0);
        send(0, 5'b00000, 5'd10, 5'd2, 5'd0, 3'd2, 7'd0,   32'd2047,      1, {1'b0, 32'h7FF1_2503}, '0);
        send(0, 5'b00100, 5'd1,  5'd0, 5'd0, 3'd0, 7'd0,   -32'sd2048,    1, {1'b0, 32'h8000_0093}, '0);
        send(0, 5'b00100, 5'd1,  5'd0, 5'd0, 3'd0, 7'd0,   32'd4096,      1, {1'b1, 32'h0000_0093}, '0);
        send(0, 5'b00100, 5'd0,  5'd0, 5'd0, 3'd0, 7'd0,   32'd2048,      1, {1'b1, 32'h8000_0013}, '0);
        send(0, 5'b11000, 5'd0,  5'd0, 5'd0, 3'd0, 7'd0,   32'd3,         1, {1'b1, 32'h0000_0163}, '0);
        send(0, 5'b11000, 5'd0,  5'd0, 5'd0, 3'd0, 7'd0,   32'd4094,      1, {1'b0, 32'h7E00_0FE3}, '0);
        send(0, 5'b11000, 5'd0,  5'd0, 5'd0, 3'd0, 7'd0,   32'd4096,      1, {1'b1, 32'h8000_0063}, '0);
        send(0, 5'b11011, 5'd0,  5'd0, 5'd0, 3'd0, 7'd0,   32'hFFF0_0000, 1, {1'b0, 32'h8000_006F}, '0);
        send(0, 5'b11011, 5'd0,  5'd0, 5'd0, 3'd0, 7'd0,   32'h0010_0000, 1, {1'b1, 32'h8000_006F}, '0);
        send(0, 5'b11011, 5'd0,  5'd0, 5'd0, 3'd0, 7'd0,   32'd1,         1, {1'b1, 32'h0000_006F}, '0);
        send(0, 5'b00111, 5'd9,  5'd3, 5'd4, 3'd5, 7'h7F,  32'd0,         1, {1'b1, 32'h0000_0013}, '0);
        wait_drain();
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL formats_missing[%0d]: got none required %h err=%b", idx, e[31:0], e[32]); end
            else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL formats[%0d]: got %h err=%b required %h err=%b", idx, o[31:0], o[32], e[31:0], e[32]); end end
            idx++;
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL formats_extra: got %0d extra words required 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_li();
        logic [32:0] e, o;
        out_ready = 1'b1;
        send(1, 5'b00000, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF, 2, {1'b0, 32'h1234_62B7}, {1'b0, 32'hFFF2_8293});
        @(negedge clk);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL li_lo_in_ready: got %b required 0", in_ready); end
        tests++; if (instr !== 32'h1234_62B7) begin fails++; $display("FAIL li_lui_word: got %h required 123462B7", instr); end
        @(negedge clk);
        tests++; if ({out_valid, instr} !== {1'b1, 32'hFFF2_8293}) begin fails++; $display("FAIL li_addi_next: got vld=%b %h required vld=1 FFF28293", out_valid, instr); end
        @(posedge clk); #1;
        send(1, 5'b00000, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000, 1, {1'b0, 32'h0000_12B7}, '0);
        send(1, 5'b00000, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 2, {1'b0, 32'h0000_12B7}, {1'b0, 32'h8002_8293});
        send(1, 5'b00111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1, {1'b0, 32'hFFF0_0293}, '0);
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL li_missing: got none required %h err=%b", e[31:0], e[32]); end
            else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL li_sb: got %h err=%b required %h err=%b", o[31:0], o[32], e[31:0], e[32]); end end
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL li_extra: got %0d extra words required 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_backpressure();
        logic [32:0] e, o;
        bit acc;
        out_ready = 1'b0;
        send(0, 5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, {1'b0, 32'h0050_0093}, '0);
        li = 1'b0; opc = 5'b11011; rd = 5'd1; imm = 32'd8; in_valid = 1'b1;
        exp_q.push_back({1'b0, 32'h0080_00EF});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++; if ({out_valid, err, instr} !== {1'b1, 1'b0, 32'h0050_0093}) begin fails++; $display("FAIL bp_hold[%0d]: got vld=%b %h err=%b required vld=1 00500093 err=0", k, out_valid, instr, err); end
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d]: got %b required 0", k, in_ready); end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin acc = 1'b1; break; end
        end
        tests++; if (!acc) begin fails++; $display("FAIL bp_release: in_ready got 0 required 1"); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL bp_missing: got none required %h err=%b", e[31:0], e[32]); end
            else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL bp_sb: got %h err=%b required %h err=%b", o[31:0], o[32], e[31:0], e[32]); end end
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL bp_extra: got %0d extra words required 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_back_to_back();
        logic [32:0] e, o;
        int c0;
        out_ready = 1'b1;
        c0 = cyc;
        send(0, 5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, {1'b0, 32'h0050_0093}, '0);
        send(1, 5'b00000, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF, 2, {1'b0, 32'h1234_62B7}, {1'b0, 32'hFFF2_8293});
        send(0, 5'b01101, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000, 1, {1'b0, 32'hABCD_E3B7}, '0);
        send(0, 5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1, {1'b0, 32'h0080_00EF}, '0);
        tests++; if (cyc - c0 != 5) begin fails++; $display("FAIL b2b_cycles: got %0d cycles required 5", cyc - c0); end
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL b2b_missing: got none required %h err=%b", e[31:0], e[32]); end
            else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL b2b_sb: got %h err=%b required %h err=%b", o[31:0], o[32], e[31:0], e[32]); end end
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL b2b_extra: got %0d extra words required 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_li();
        logic [32:0] e, o;
        out_ready = 1'b0;
        send(1, 5'b00000, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF, 0, '0, '0);
        @(negedge clk);
        tests++; if ({in_ready, instr} !== {1'b0, 32'h1234_62B7}) begin fails++; $display("FAIL rli_pending: got rdy=%b %h required rdy=0 123462B7", in_ready, instr); end
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1; li = 1'b0; opc = 5'b00100; rd = 5'd1; imm = 32'd5;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        tests++; if ({out_valid, instr, in_ready} !== {1'b0, 32'd0, 1'b1}) begin fails++; $display("FAIL rli_after_rst: got vld=%b %h rdy=%b required vld=0 00000000 rdy=1", out_valid, instr, in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL rli_no_addi: got %0d words required 0", obs_q.size()); obs_q.delete(); end
        @(posedge clk); #1;
        send(0, 5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1, {1'b0, 32'h0080_00EF}, '0);
        wait_drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin fails++; $display("FAIL rli_missing: got none required %h err=%b", e[31:0], e[32]); end
            else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL rli_sb: got %h err=%b required %h err=%b", o[31:0], o[32], e[31:0], e[32]); end end
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL rli_extra: got %0d extra words required 0", obs_q.size()); obs_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_formats();
        test_li();
        test_backpressure();
        test_back_to_back();
        test_reset_li();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk input, rst input.
REQ-002 The module SHALL have the following parameter: none; all widths are fixed by RV32I.
REQ-003 The module SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted on the edge where in_valid&in_ready.
- opc  in  5  instruction class, equal to opcode[6:2]: 01100 R, 00100 OP-IMM, 00000 LOAD, 01000 STORE, 11000 BRANCH, 01101 LUI, 00101 AUIPC, 11011 JAL, 11001 JALR.
- li  in  1  pseudo-op load-immediate; opc is ignored when li=1.
- rd, rs1, rs2  in  5 each  register fields.
- funct3  in  3  function field.
- funct7  in  7  function field (R class only).
- imm  in  32  signed byte-offset / value; U class takes imm[31:12].
- out_valid  out  1  instr valid.
- out_ready  in  1  consumer accepts on the edge where out_valid&out_ready.
- instr  out  32  encoded instruction.
- err  out  1  qualifies instr; imm not representable, or opc unsupported.

Function
REQ-004 The module SHALL hold a one-entry output register (instr, err, out_valid); a word SHALL appear on out_valid exactly 1 cycle after acceptance.
REQ-005 in_ready SHALL be (!out_valid | out_ready) when state is IDLE, and 0 in state LI_LO.
REQ-006 While out_valid=1 and out_ready=0, instr and err SHALL remain stable.
REQ-007 instr[6:0] SHALL be {opc,2'b11}; rd->[11:7], funct3->[14:12], rs1->[19:15], rs2->[24:20], placed only where the format defines them.
REQ-008 R: [31:25]=funct7. I (OP-IMM, LOAD, JALR): [31:20]=imm[11:0]. S: [31:25]=imm[11:5], [11:7]=imm[4:0]. B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]. U: [31:12]=imm[31:12]. J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
REQ-009 err SHALL be asserted under the following conditions; the truncated encoding is still emitted.
- I/S: imm outside [-2048, 2047].
- B: imm outside [-4096, 4094], or imm[0]=1.
- J: imm outside [-2^20, 2^20-2], or imm[0]=1.
- U: imm[11:0] != 0.
REQ-010 An unsupported opc with li=0 SHALL emit 0x00000013 (NOP) with err=1.
REQ-011 The state machine SHALL have the states IDLE and LI_LO.
REQ-012 li with imm in [-2048, 2047] SHALL emit a single ADDI rd,x0,imm[11:0] (0010011, funct3=000), and the state SHALL remain IDLE.
REQ-013 li otherwise SHALL emit LUI rd,hi, where hi=(imm+32'h800)[31:12], computed mod 2^32.
- If imm[11:0]!=0: state SHALL go to LI_LO, latching rd and imm[11:0].
- Otherwise: no second word; state SHALL remain IDLE.
REQ-014 In LI_LO, once the LUI word is consumed (or the register is empty), the module SHALL emit ADDI rd,rd,imm[11:0] and return to IDLE; the next word SHALL be accepted no earlier than the cycle after the ADDI is loaded.
REQ-015 li SHALL never set err.
REQ-016 The module SHALL hold no other state; throughput SHALL be 1 word/cycle under out_ready=1, and 2 cycles for a two-word li.

Reset
REQ-017 When rst=1 at a clk edge, the next values SHALL be out_valid=0, instr=0, err=0, state=IDLE, with in_ready=1 after reset.
REQ-018 Reset in LI_LO SHALL drop the pending ADDI, and rst SHALL override a simultaneous in_valid.
REQ-019 There SHALL be no reset-free storage affecting outputs.

Verification
REQ-020 opc=00100, rd=1, rs1=0, funct3=0, imm=5 -> instr=0x00500093, err=0, one cycle after acceptance.
REQ-021 opc=11000, rs1=1, rs2=2, funct3=0, imm=-4 -> 0xFE208EE3; and opc=11011, rd=1, imm=8 -> 0x008000EF.
REQ-022 li, rd=5, imm=0x12345FFF -> 0x123462B7 then 0xFFF28293 on consecutive words; in_ready=0 during LI_LO. li, imm=0x00001000 -> single 0x000012B7.
REQ-023 opc=00100, imm=4096 -> err=1, instr[31:20]=0x000; opc=11000, imm=3 -> err=1; opc=00111 -> 0x00000013, err=1.
REQ-024 Hold out_ready=0 for 5 cycles with in_valid=1 -> instr stable, in_ready=0, no word lost or duplicated when out_ready rises.
REQ-025 Assert rst during LI_LO -> out_valid=0 next cycle, the ADDI is never emitted, and the next request encodes normally.
